// File: rtl/div_freq_bank.sv
// Fixed-ratio divider bank: three independent 50% duty square waves derived from CLK,
// each with a one-cycle strobe marking its rising transition.

module div_chan #(
   parameter int HALF = 1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   output logic div_o,
   output logic tick_o
);

   localparam int W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [W-1:0] LAST = W'(HALF - 1);

   if (HALF < 1) begin : g_bad_half
      $error("div_chan: half period must be at least one CLK cycle");
   end

   logic [W-1:0] cnt_q, cnt_d;
   logic         div_q, div_d;
   logic         tick_q, tick_d;
   logic         wrap;

   // The strobe is computed from the pre-toggle level, so it lands in the same
   // cycle the divided clock first reads high.
   always_comb begin
      wrap   = (cnt_q == LAST);
      cnt_d  = wrap ? '0 : cnt_q + W'(1);
      div_d  = div_q ^ wrap;
      tick_d = wrap & ~div_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q  <= '0;
         div_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   assign div_o  = div_q;
   assign tick_o = tick_q;

endmodule

module div_freq_bank #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int F_FAST   = 1000,
   parameter int F_MID    = 5,
   parameter int F_SLOW   = 1
) (
   input  logic CLK,
   input  logic RST_N,
   output logic CLK_div,
   output logic CLK_div5,
   output logic CLK_div1,
   output logic TICK_div,
   output logic TICK_div5,
   output logic TICK_div1
);

   // A zero frequency maps to HALF=0 so the channel reports it instead of dividing by zero.
   localparam int HALF_FAST = (F_FAST == 0) ? 0 : CLK_FREQ / (2 * F_FAST);
   localparam int HALF_MID  = (F_MID  == 0) ? 0 : CLK_FREQ / (2 * F_MID);
   localparam int HALF_SLOW = (F_SLOW == 0) ? 0 : CLK_FREQ / (2 * F_SLOW);

   div_chan #(.HALF(HALF_FAST)) u_fast (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .div_o   (CLK_div),
      .tick_o  (TICK_div)
   );

   div_chan #(.HALF(HALF_MID)) u_mid (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .div_o   (CLK_div5),
      .tick_o  (TICK_div5)
   );

   div_chan #(.HALF(HALF_SLOW)) u_slow (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .div_o   (CLK_div1),
      .tick_o  (TICK_div1)
   );

endmodule

// File: tb/tb_div_freq_bank.sv
// Directed bench for div_freq_bank: small-ratio, HALF=1, truncating and default instances
// checked edge by edge against a closed-form model of each channel.

module tb_div_freq_bank;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;

   always #5 CLK = ~CLK;

   // inst A: HALF 5/10/50; B: HALF 1/2/2; C: HALF 1/5/50; D: defaults
   logic a_d, a_d5, a_d1, a_t, a_t5, a_t1;
   logic b_d, b_d5, b_d1, b_t, b_t5, b_t1;
   logic c_d, c_d5, c_d1, c_t, c_t5, c_t1;
   logic d_d, d_d5, d_d1, d_t, d_t5, d_t1;

   div_freq_bank #(.CLK_FREQ(1000), .F_FAST(100), .F_MID(50), .F_SLOW(10)) u_a (
      .CLK(CLK), .RST_N(RST_N), .CLK_div(a_d), .CLK_div5(a_d5), .CLK_div1(a_d1),
      .TICK_div(a_t), .TICK_div5(a_t5), .TICK_div1(a_t1));

   div_freq_bank #(.CLK_FREQ(4), .F_FAST(2), .F_MID(1), .F_SLOW(1)) u_b (
      .CLK(CLK), .RST_N(RST_N), .CLK_div(b_d), .CLK_div5(b_d5), .CLK_div1(b_d1),
      .TICK_div(b_t), .TICK_div5(b_t5), .TICK_div1(b_t1));

   div_freq_bank #(.CLK_FREQ(1000), .F_FAST(300), .F_MID(100), .F_SLOW(10)) u_c (
      .CLK(CLK), .RST_N(RST_N), .CLK_div(c_d), .CLK_div5(c_d5), .CLK_div1(c_d1),
      .TICK_div(c_t), .TICK_div5(c_t5), .TICK_div1(c_t1));

   div_freq_bank u_d (
      .CLK(CLK), .RST_N(RST_N), .CLK_div(d_d), .CLK_div5(d_d5), .CLK_div1(d_d1),
      .TICK_div(d_t), .TICK_div5(d_t5), .TICK_div1(d_t1));

   int checks = 0;
   int errors = 0;
   int e = 0;
   int n_t = 0, n_t5 = 0, n_t1 = 0;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Level after edge n of a channel with half period h (n=0: just out of reset).
   function automatic logic mdiv(input int n, input int h);
      return ((n / h) % 2) == 1;
   endfunction

   function automatic logic mtick(input int n, input int h);
      return (n % (2 * h)) == h;
   endfunction

   task automatic chk_chan(input string tag, input logic d, input logic t, input int h);
      chk({tag, "_div"}, d, mdiv(e, h));
      chk({tag, "_tick"}, t, mtick(e, h));
   endtask

   task automatic chk_all();
      chk_chan("a_fast", a_d,  a_t,  5);
      chk_chan("a_mid",  a_d5, a_t5, 10);
      chk_chan("a_slow", a_d1, a_t1, 50);
      chk_chan("b_fast", b_d,  b_t,  1);
      chk_chan("b_mid",  b_d5, b_t5, 2);
      chk_chan("b_slow", b_d1, b_t1, 2);
      chk_chan("c_fast", c_d,  c_t,  1);
      chk_chan("c_mid",  c_d5, c_t5, 5);
      chk_chan("c_slow", c_d1, c_t1, 50);
      chk_chan("d_fast", d_d,  d_t,  25_000);
      chk_chan("d_mid",  d_d5, d_t5, 5_000_000);
      chk_chan("d_slow", d_d1, d_t1, 25_000_000);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      e++;
      if (a_t)  n_t++;
      if (a_t5) n_t5++;
      if (a_t1) n_t1++;
      chk_all();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_a"}, a_d | a_d5 | a_d1 | a_t | a_t5 | a_t1, 1'b0);
      chk({tag, "_b"}, b_d | b_d5 | b_d1 | b_t | b_t5 | b_t1, 1'b0);
      chk({tag, "_c"}, c_d | c_d5 | c_d1 | c_t | c_t5 | c_t1, 1'b0);
      chk({tag, "_d"}, d_d | d_d5 | d_d1 | d_t | d_t5 | d_t1, 1'b0);
   endtask

   task automatic release_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      e = 0;
      n_t = 0; n_t5 = 0; n_t1 = 0;
   endtask

   initial begin
      #2;
      chk_all_zero("reset_state");
      repeat (3) @(posedge CLK);
      #1;
      chk_all_zero("reset_held");

      // Long run: per-edge levels and strobes, plus strobe totals.
      release_reset();
      chk_all();
      repeat (1000) step();
      chk_int("a_tick_fast_count", n_t, 100);
      chk_int("a_tick_mid_count",  n_t5, 50);
      chk_int("a_tick_slow_count", n_t1, 10);

      // Asynchronous reset between edges, mid-period.
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      release_reset();
      repeat (37) step();
      chk("pre_abort_a_fast_high", a_d, 1'b1);
      #2;
      RST_N = 1'b0;
      #1;
      chk_all_zero("async_abort");
      repeat (2) @(posedge CLK);
      #1;
      chk_all_zero("abort_held");
      release_reset();
      repeat (12) step();

      // Default ratios: first fast rise at edge 25000.
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      release_reset();
      repeat (24_999) step();
      chk("default_fast_before_rise", d_d, 1'b0);
      step();
      chk("default_fast_rise", d_d, 1'b1);
      chk("default_fast_tick", d_t, 1'b1);
      chk("default_mid_low", d_d5, 1'b0);
      chk("default_slow_low", d_d1, 1'b0);
      step();
      chk("default_fast_tick_drop", d_t, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
